// File: rtl/vstream_pkt.sv
// vstream_pkt -- packetised byte stream to frame-buffer writer.
//
// Decodes framed byte packets (first/last/valid/ready) into frame-buffer
// operations: pixel writes, back-buffer row store/swap and frame swap.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_data/first/    input byte stream; a byte is accepted when
//   last/valid/ready  in_valid & in_ready
//   status            {err, 5'd0, frame_rdy, fbw_row_rdy}
//   err_clr           clears the sticky error flag
//   fbw_row_*         row address, store/swap pulses, row-ready input
//   fbw_data/col_addr pixel write data (first stream byte in [7:0]),
//   fbw_wren          column and write strobe
//   frame_swap        frame swap pulse, gated by frame_rdy
//
// Opcodes: 0x80 PIXELS, 0x01 ROW_STORE, 0x02 ROW_SWAP, 0x03 ROW_STORE+SWAP,
// 0x04 FRAME_SWAP. All outputs are registered.
module vstream_pkt #(
  parameter int N_ROWS     = 64,
  parameter int N_COLS     = 64,
  parameter int BITDEPTH   = 16,
  parameter int LOG_N_ROWS = $clog2(N_ROWS),
  parameter int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            status,
  input  logic                  err_clr,
  output logic [LOG_N_ROWS-1:0] fbw_row_addr,
  output logic                  fbw_row_store,
  input  logic                  fbw_row_rdy,
  output logic                  fbw_row_swap,
  output logic [BITDEPTH-1:0]   fbw_data,
  output logic [LOG_N_COLS-1:0] fbw_col_addr,
  output logic                  fbw_wren,
  output logic                  frame_swap,
  input  logic                  frame_rdy
);

  localparam int TW = BITDEPTH / 8;
  localparam int CW = (TW > 1) ? $clog2(TW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TW - 1);
  // Column tracked with 9 bits so positions past the last column stay detectable.
  localparam logic [8:0] COL_LIMIT = 9'(N_COLS);

  typedef enum logic [2:0] {
    IDLE, PIX_COL, PIX_DATA, ROW_ARG, ROW_WAIT, FRAME_WAIT, SKIP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [8:0]            col_q, col_d;
  logic [BITDEPTH-1:0]   pix_q, pix_d;
  logic [1:0]            row_op_q, row_op_d;     // {swap, store}
  logic                  cmd_last_q, cmd_last_d; // command ended its packet
  logic                  err_q, err_d, err_set;
  logic                  in_ready_q, in_ready_d;
  logic [7:0]            status_q, status_d;
  logic [LOG_N_ROWS-1:0] row_addr_q, row_addr_d;
  logic                  row_store_q, row_store_d;
  logic                  row_swap_q, row_swap_d;
  logic                  wren_q, wren_d;
  logic                  frame_swap_q, frame_swap_d;
  logic [BITDEPTH-1:0]   data_q, data_d;
  logic [LOG_N_COLS-1:0] col_addr_q, col_addr_d;
  logic                  take;

  // Next-state and next-output computation for the packet decoder.
  always_comb begin
    take         = in_valid & in_ready_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    col_d        = col_q;
    pix_d        = pix_q;
    row_op_d     = row_op_q;
    cmd_last_d   = cmd_last_q;
    err_set      = 1'b0;
    row_addr_d   = row_addr_q;
    row_store_d  = 1'b0;
    row_swap_d   = 1'b0;
    wren_d       = 1'b0;
    frame_swap_d = 1'b0;
    data_d       = data_q;
    col_addr_d   = col_addr_q;

    case (state_q)
      ROW_WAIT: begin
        if (fbw_row_rdy) begin
          row_store_d = row_op_q[0];
          row_swap_d  = row_op_q[1];
          // Bytes left in the packet after a complete command are an error.
          err_set     = ~cmd_last_q;
          state_d     = cmd_last_q ? IDLE : SKIP;
        end else begin
          state_d = ROW_WAIT;
        end
      end
      FRAME_WAIT: begin
        if (frame_rdy) begin
          frame_swap_d = 1'b1;
          err_set      = ~cmd_last_q;
          state_d      = cmd_last_q ? IDLE : SKIP;
        end else begin
          state_d = FRAME_WAIT;
        end
      end
      default: begin
        if (!take) begin
          state_d = state_q;
        end else if (in_first) begin
          // A new opcode outside IDLE aborts the current packet.
          err_set = (state_q != IDLE);
          cnt_d   = '0;
          case (in_data)
            8'h80: begin
              if (in_last) begin
                err_set = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = PIX_COL;
              end
            end
            8'h01, 8'h02, 8'h03: begin
              row_op_d = in_data[1:0];
              if (in_last) begin
                err_set = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = ROW_ARG;
              end
            end
            8'h04: begin
              cmd_last_d = in_last;
              state_d    = FRAME_WAIT;
            end
            default: begin
              err_set = 1'b1;
              state_d = in_last ? IDLE : SKIP;
            end
          endcase
        end else begin
          case (state_q)
            PIX_COL: begin
              col_d   = {1'b0, in_data};
              cnt_d   = '0;
              state_d = in_last ? IDLE : PIX_DATA;
            end
            PIX_DATA: begin
              pix_d[{cnt_q, 3'b000} +: 8] = in_data;
              if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (col_q < COL_LIMIT) begin
                  wren_d     = 1'b1;
                  data_d     = pix_d;
                  col_addr_d = col_q[LOG_N_COLS-1:0];
                  col_d      = col_q + 9'd1;
                end else begin
                  err_set = 1'b1;
                  col_d   = col_q;   // saturate once past the row end
                end
              end else begin
                cnt_d   = cnt_q + CW'(1);
                err_set = in_last;   // partial pixel at packet end
              end
              state_d = in_last ? IDLE : PIX_DATA;
            end
            ROW_ARG: begin
              row_addr_d = in_data[LOG_N_ROWS-1:0];
              cmd_last_d = in_last;
              state_d    = ROW_WAIT;
            end
            SKIP: begin
              state_d = in_last ? IDLE : SKIP;
            end
            default: begin
              // Continuation byte with no packet open.
              err_set = 1'b1;
              state_d = in_last ? IDLE : SKIP;
            end
          endcase
        end
      end
    endcase

    err_d      = err_set | (err_q & ~err_clr);
    in_ready_d = (state_d != ROW_WAIT) && (state_d != FRAME_WAIT);
    status_d   = {err_d, 5'd0, frame_rdy, fbw_row_rdy};
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      col_q        <= 9'd0;
      pix_q        <= '0;
      row_op_q     <= 2'b00;
      cmd_last_q   <= 1'b0;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      status_q     <= 8'd0;
      row_addr_q   <= '0;
      row_store_q  <= 1'b0;
      row_swap_q   <= 1'b0;
      wren_q       <= 1'b0;
      frame_swap_q <= 1'b0;
      data_q       <= '0;
      col_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      pix_q        <= pix_d;
      row_op_q     <= row_op_d;
      cmd_last_q   <= cmd_last_d;
      err_q        <= err_d;
      in_ready_q   <= in_ready_d;
      status_q     <= status_d;
      row_addr_q   <= row_addr_d;
      row_store_q  <= row_store_d;
      row_swap_q   <= row_swap_d;
      wren_q       <= wren_d;
      frame_swap_q <= frame_swap_d;
      data_q       <= data_d;
      col_addr_q   <= col_addr_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign status        = status_q;
  assign fbw_row_addr  = row_addr_q;
  assign fbw_row_store = row_store_q;
  assign fbw_row_swap  = row_swap_q;
  assign fbw_data      = data_q;
  assign fbw_col_addr  = col_addr_q;
  assign fbw_wren      = wren_q;
  assign frame_swap    = frame_swap_q;

endmodule

// File: tb/tb_vstream_pkt.sv
// Testbench for vstream_pkt: directed packets with literal expectations plus
// randomized packet streams checked against a packet-level reference model.
module tb_vstream_pkt;
  localparam int N_ROWS   = 64;
  localparam int N_COLS   = 64;
  localparam int BITDEPTH = 16;
  localparam int TW       = BITDEPTH / 8;
  localparam int LR       = 6;
  localparam int LC       = 6;

  typedef logic [7:0] bytes_t[$];

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          in_data = 8'd0;
  logic                in_first = 1'b0, in_last = 1'b0, in_valid = 1'b0;
  logic                in_ready;
  logic [7:0]          status;
  logic                err_clr = 1'b0;
  logic [LR-1:0]       fbw_row_addr;
  logic                fbw_row_store, fbw_row_swap, fbw_row_rdy;
  logic [BITDEPTH-1:0] fbw_data;
  logic [LC-1:0]       fbw_col_addr;
  logic                fbw_wren, frame_swap, frame_rdy;

  // Ready inputs: manual values in directed tests, random in the random phase.
  bit   rand_rdy = 1'b0;
  logic man_row_rdy = 1'b0, man_fr_rdy = 1'b0;
  logic rnd_row_rdy = 1'b0, rnd_fr_rdy = 1'b0;
  assign fbw_row_rdy = rand_rdy ? rnd_row_rdy : man_row_rdy;
  assign frame_rdy   = rand_rdy ? rnd_fr_rdy  : man_fr_rdy;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard of expected events.
  int                  exp_wr_col[$];
  logic [BITDEPTH-1:0] exp_wr_data[$];
  logic [7:0]          exp_row[$];   // {swap, store, row}
  int                  exp_frames = 0;
  bit                  exp_err = 1'b0;
  logic [7:0]          row_e;

  vstream_pkt #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .BITDEPTH(BITDEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_first(in_first),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .status(status), .err_clr(err_clr), .fbw_row_addr(fbw_row_addr),
    .fbw_row_store(fbw_row_store), .fbw_row_rdy(fbw_row_rdy),
    .fbw_row_swap(fbw_row_swap), .fbw_data(fbw_data),
    .fbw_col_addr(fbw_col_addr), .fbw_wren(fbw_wren),
    .frame_swap(frame_swap), .frame_rdy(frame_rdy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    rnd_row_rdy = ($urandom_range(0, 2) != 0);
    rnd_fr_rdy  = ($urandom_range(0, 2) != 0);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Packet-level reference: one segment runs from an opcode byte to its last
  // byte, or is cut short by the next opcode (last == 0).
  task automatic model_seg(input bytes_t b, input bit last, output bit e);
    int n, col, npx;
    logic [BITDEPTH-1:0] px;
    logic [7:0] op, arg;
    n  = b.size();
    op = b[0];
    e  = !last;
    if (op == 8'h80) begin
      if (n < 2) begin
        e = 1'b1;
      end else begin
        col = int'(b[1]);
        npx = (n - 2) / TW;
        for (int k = 0; k < npx; k++) begin
          px = '0;
          for (int j = 0; j < TW; j++) px = px | (BITDEPTH'(b[2 + k*TW + j]) << (8*j));
          if (col + k < N_COLS) begin
            exp_wr_col.push_back(col + k);
            exp_wr_data.push_back(px);
          end else begin
            e = 1'b1;
          end
        end
        if ((n - 2) % TW != 0) e = 1'b1;
      end
    end else if (op >= 8'h01 && op <= 8'h03) begin
      if (n >= 2) begin
        arg = b[1];
        exp_row.push_back({op[1:0], arg[LR-1:0]});
      end
      if (n != 2) e = 1'b1;
    end else if (op == 8'h04) begin
      exp_frames++;
      if (n != 1) e = 1'b1;
    end else begin
      e = 1'b1;
    end
  endtask

  // Drive one byte from a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] d, input logic f, input logic l);
    int waited = 0;
    in_data = d; in_first = f; in_last = l; in_valid = 1'b1;
    while (!in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_seg(input bytes_t b, input bit last, input bit gaps);
    bit e;
    model_seg(b, last, e);
    exp_err = exp_err | e;
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], i == 0, last && (i == b.size() - 1));
      if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
    end
  endtask

  task automatic wait_quiet();
    int waited = 0;
    while (!in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("quiet_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
  endtask

  // Per-cycle compare against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("status_low", 64'(status[6:0]), 64'({frame_rdy, fbw_row_rdy}));
      if (fbw_wren) begin
        check("wren_expected", 64'(exp_wr_col.size() > 0), 64'd1);
        if (exp_wr_col.size() > 0) begin
          check("wr_col", 64'(fbw_col_addr), 64'(exp_wr_col.pop_front()));
          check("wr_data", 64'(fbw_data), 64'(exp_wr_data.pop_front()));
        end
      end
      if (fbw_row_store | fbw_row_swap) begin
        check("row_expected", 64'(exp_row.size() > 0), 64'd1);
        if (exp_row.size() > 0) begin
          row_e = exp_row.pop_front();
          check("row_pulse", 64'({fbw_row_swap, fbw_row_store, fbw_row_addr}), 64'(row_e));
        end
      end
      if (frame_swap) begin
        check("frame_expected", 64'(exp_frames > 0), 64'd1);
        if (exp_frames > 0) exp_frames--;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_t b;
    bit     e, last;
    int     kind, npx;
    logic [7:0] op;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_status", 64'(status), 64'h00);
    check("rst_pulses", 64'({fbw_wren, fbw_row_store, fbw_row_swap, frame_swap}), 64'd0);
    check("rst_data", 64'({fbw_data, fbw_col_addr, fbw_row_addr}), 64'd0);

    // Pixel packet: two pixels from column 5, each written one cycle after its beat.
    b = {8'h80, 8'h05, 8'h34, 8'h12, 8'h78, 8'h56};
    model_seg(b, 1'b1, e);
    check("model_pix_cnt", 64'(exp_wr_col.size()), 64'd2);
    check("model_pix_d0", 64'(exp_wr_data[0]), 64'h1234);
    check("model_pix_d1", 64'(exp_wr_data[1]), 64'h5678);
    send_byte(8'h80, 1'b1, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    check("pix0_wren", 64'(fbw_wren), 64'd1);
    check("pix0_col", 64'(fbw_col_addr), 64'd5);
    check("pix0_data", 64'(fbw_data), 64'h1234);
    send_byte(8'h78, 1'b0, 1'b0);
    check("pix_mid_wren", 64'(fbw_wren), 64'd0);
    send_byte(8'h56, 1'b0, 1'b1);
    check("pix1_wren", 64'(fbw_wren), 64'd1);
    check("pix1_col", 64'(fbw_col_addr), 64'd6);
    check("pix1_data", 64'(fbw_data), 64'h5678);
    wait_quiet();
    check("pix_err", 64'(status[7]), 64'd0);

    // Row store with the row buffer busy for 10 cycles.
    b = {8'h01, 8'h07};
    model_seg(b, 1'b1, e);
    check("model_row", 64'(exp_row[0]), 64'h47);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h07, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("row_stall_ready", 64'(in_ready), 64'd0);
      check("row_stall_store", 64'(fbw_row_store), 64'd0);
      @(negedge clk);
    end
    man_row_rdy = 1'b1;
    @(negedge clk);
    check("row_store", 64'({fbw_row_store, fbw_row_swap}), 64'b10);
    check("row_addr", 64'(fbw_row_addr), 64'd7);
    check("row_ready_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("row_store_once", 64'(fbw_row_store), 64'd0);

    // Store and swap in the same cycle.
    b = {8'h03, 8'h2A};
    send_seg(b, 1'b1, 1'b0);
    wait_quiet();
    check("row_both_addr", 64'(fbw_row_addr), 64'd42);
    man_row_rdy = 1'b0;

    // Frame swap waits for frame_rdy.
    b = {8'h04};
    model_seg(b, 1'b1, e);
    check("model_frame", 64'(exp_frames), 64'd1);
    send_byte(8'h04, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("frame_stall_ready", 64'(in_ready), 64'd0);
      check("frame_stall_swap", 64'(frame_swap), 64'd0);
      @(negedge clk);
    end
    man_fr_rdy = 1'b1;
    @(negedge clk);
    check("frame_swap", 64'(frame_swap), 64'd1);
    check("frame_ready_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("frame_swap_once", 64'(frame_swap), 64'd0);
    man_fr_rdy = 1'b0;
    @(negedge clk);

    // Column overflow: column 63 written, column 64 dropped with error.
    b = {8'h80, 8'h3F, 8'h11, 8'h22, 8'h33, 8'h44};
    model_seg(b, 1'b1, e);
    check("model_ovf_cnt", 64'(exp_wr_col.size()), 64'd1);
    check("model_ovf_err", 64'(e), 64'd1);
    foreach (b[i]) send_byte(b[i], i == 0, i == b.size() - 1);
    wait_quiet();
    check("ovf_err", 64'(status[7]), 64'd1);
    clear_err();
    check("ovf_clr", 64'(status), 64'h00);

    // Partial pixel at packet end.
    b = {8'h80, 8'h00, 8'hAA};
    model_seg(b, 1'b1, e);
    check("model_part_err", 64'(e), 64'd1);
    foreach (b[i]) send_byte(b[i], i == 0, i == b.size() - 1);
    wait_quiet();
    check("part_err", 64'(status[7]), 64'd1);
    clear_err();
    check("part_clr", 64'(status), 64'h00);

    // Reset during pixel data after one byte: nothing written.
    send_byte(8'h80, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hAB, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    check("rst_mid_ready", 64'(in_ready), 64'd1);
    check("rst_mid_wren", 64'(fbw_wren), 64'd0);
    b = {8'h80, 8'h02, 8'hCD, 8'hAB};
    send_seg(b, 1'b1, 1'b0);
    wait_quiet();
    check("after_rst_col", 64'(fbw_col_addr), 64'd2);
    check("after_rst_data", 64'(fbw_data), 64'hABCD);
    check("after_rst_err", 64'(status[7]), 64'd0);

    // Randomized packet stream.
    rand_rdy = 1'b1;
    for (int s = 0; s < 300; s++) begin
      b = {};
      kind = $urandom_range(0, 9);
      last = ($urandom_range(0, 9) != 0);
      if (kind <= 3 || kind == 9) begin
        b.push_back(8'h80);
        if ($urandom_range(0, 3) == 0) b.push_back(8'($urandom_range(N_COLS - 3, N_COLS + 1)));
        else b.push_back(8'($urandom_range(0, N_COLS - 1)));
        npx = $urandom_range(0, 4);
        for (int i = 0; i < npx * TW; i++) b.push_back(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 5) == 0)
          for (int i = 0; i < $urandom_range(1, TW - 1); i++) b.push_back(8'($urandom_range(0, 255)));
      end else if (kind <= 5) begin
        b.push_back(8'($urandom_range(1, 3)));
        b.push_back(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 5) == 0) b.push_back(8'($urandom_range(0, 255)));
      end else if (kind == 6) begin
        b.push_back(8'h04);
        if ($urandom_range(0, 5) == 0) b.push_back(8'($urandom_range(0, 255)));
      end else if (kind == 7) begin
        do op = 8'($urandom_range(0, 255));
        while (op == 8'h80 || (op >= 8'h01 && op <= 8'h04));
        b.push_back(op);
        for (int i = 0; i < $urandom_range(0, 2); i++) b.push_back(8'($urandom_range(0, 255)));
      end else begin
        b.push_back(($urandom_range(0, 1) == 0) ? 8'h80 : 8'($urandom_range(1, 3)));
      end
      send_seg(b, last, 1'b1);
      if (last) begin
        wait_quiet();
        check("rand_err", 64'(status[7]), 64'(exp_err));
        if ($urandom_range(0, 2) == 0) clear_err();
      end
    end

    // Close any open packet and drain.
    b = {8'h04};
    send_seg(b, 1'b1, 1'b0);
    wait_quiet();
    repeat (3) @(negedge clk);
    check("final_err", 64'(status[7]), 64'(exp_err));
    check("final_wr_left", 64'(exp_wr_col.size()), 64'd0);
    check("final_row_left", 64'(exp_row.size()), 64'd0);
    check("final_frames_left", 64'(exp_frames), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
